lsu_sequencer: RTL and testbench
================================

# lsu_sequencer

Multi-cycle load/store sequencer between the RV32 core datapath and a req/ack data-memory bus. It takes the decoder's `memread`, `memwrite`, `length` and `sign` controls with the ALU-computed address and store data. It then:
- stalls the core while it drives byte-lane-correct bus transactions;
- returns aligned, sign- or zero-extended load data.

## Interface
- `BUS_TIMEOUT`, default 64: max cycles a bus request waits for `bus_ack` before aborting with error.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `memread`  in  1  load request. The core gates it with the load opcode.
- `memwrite`  in  1  store request.
- `length`  in  2  access size: 00 word, 01 byte, 10 halfword, 11 reserved.
- `sign`  in  1  1 = sign-extend load, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `stall`  out  1  freeze PC/pipeline.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned, reserved length or timeout.
- `rdata`  out  32  load result, valid with `done`.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address, bits [1:0] = 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-shifted write data.
- `bus_ack`  in  1  transfer complete. `bus_rdata` is valid in this cycle.
- `bus_rdata`  in  32  read data.

## Operation
- **States:** IDLE, REQ1, REQ2, DONE.
- **IDLE:**
  - `stall` = `memread|memwrite`, combinational.
  - If both are high, the access is a store.
  - A legal access goes to REQ1.
  - Reserved `length` or illegal misalignment goes directly to DONE with err=1 and no bus activity.
- **REQ1/REQ2:**
  - `bus_req`=1 and `stall`=1.
  - `bus_addr`, `bus_be`, `bus_we` and `bus_wdata` are registered at entry and held stable until ack.
  - On the `bus_ack` edge: capture `bus_rdata`, then go to REQ2 (split access) or DONE.
- **DONE:**
  - `done`=1 and `stall`=0. The core advances this cycle.
  - New requests are not sampled in DONE. The next state is always IDLE.
- **Core inputs:** the core holds all inputs stable while `stall`=1.
- **Lane rules**, with o = `addr[1:0]`:
  - Byte: `be` = 1<<o.
  - Half: `be` = 3<<o.
  - Word: `be` = 4'hF.
  - `bus_wdata` = `wdata` << 8·o.
  - Load data = captured word >> 8·o, truncated to 8/16/32 bits, then extended per `sign`.
- **Misaligned:** halfword with o=3, or word with o≠0. Handling depends on `LSU_MISALIGN_SPLIT_EN` (see Configuration).
- **Timeout:**
  - A cycle counter clears on entry to each REQ state.
  - When it reaches `BUS_TIMEOUT` without ack: drop `bus_req` and go to DONE with err=1, `rdata`=0.
  - A late ack after that is ignored.
- **Stores:** `rdata`=0 on stores.

## Timing
- **Reset values:** state IDLE. `stall`, `done`, `err`, `bus_req`, `bus_we` = 0. `rdata`, `bus_addr`, `bus_be`, `bus_wdata` = 0. Timeout counter = 0.
- **Aligned access, zero wait:** request seen in cycle 0 (IDLE, stall=1). REQ1 in cycle 1 with ack. DONE in cycle 2. Total 2 stall cycles plus one per wait state.
- **Split access:** 3 cycles minimum.
- **Error without bus activity:** 1 stall cycle, then DONE.
- **Async reset mid-transaction:** aborts immediately. `bus_req` drops with `rst_n` low, with no `done` pulse.
- **Ack sampling:** `bus_ack` is sampled only while `bus_req`=1. Ack outside REQ is ignored.

## Configuration
- **`LSU_MISALIGN_SPLIT_EN` defined:** a misaligned access crossing a word boundary issues two transactions.
  - REQ1: word `addr&~3`, `be` = the low part of the lane mask.
  - REQ2: word `(addr&~3)+4`, `be` = the overflow lanes shifted down 4 bits.
  - Load data is merged from both captures. `err`=0 unless a timeout occurs.
- **Undefined:** misaligned accesses are rejected with err=1, no bus request and 1 stall cycle.

## Structure
- **Package `lsu_pkg`:**
  - `length` encodings: `LEN_WORD`=2'b00, `LEN_BYTE`=2'b01, `LEN_HALF`=2'b10.
  - State enum.
  - Function computing the 8-bit lane mask from `length` and offset.
- **Sub-module `load_align`:** combinational extract/merge of one or two captured words by offset, size and `sign`. Shared with future cache work.
- **Top level:** FSM, timeout counter and bus registers stay in `lsu_sequencer`.

## Test plan
- **Aligned word load:** load word at 0x100, `bus_rdata`=0xDEADBEEF acked in first REQ cycle → `done` in cycle 2, `rdata`=0xDEADBEEF, `bus_be`=4'hF, `stall` high in cycles 0–1.
- **Byte loads:** byte at 0x103, bus word 0x80FF_FFFF. `sign`=1 → `rdata`=0xFFFFFF80. `sign`=0 → 0x00000080. `bus_be`=4'b1000 in both cases.
- **Halfword store:** store half 0xABCD at 0x202 → `bus_addr`=0x200, `be`=4'b1100, `bus_wdata`=0xABCD_0000, `bus_we`=1. Three wait states → 5 stall cycles.
- **Misaligned word load at 0x301:**
  - Without macro: `err`=1 after 1 stall cycle, `bus_req` never high.
  - With macro: two transfers, 0x300 with `be` 1110 and 0x304 with `be` 0001. Words 0x44332211 and 0x88776655 → `rdata`=0x55443322.
- **Timeout:** `BUS_TIMEOUT`=4 and `bus_ack` held low → `bus_req` drops after 4 cycles, `done`=1, `err`=1, `rdata`=0. Ack on the next cycle is ignored.
- **Reset mid-REQ:** `rst_n` pulsed low mid-REQ → `bus_req`=0 and `stall`=0 immediately, no `done`. A later aligned load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: access-size encodings,
// FSM state enum and the byte-lane mask function.
package lsu_pkg;

  localparam logic [1:0] LEN_WORD = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ1,
    ST_REQ2,
    ST_DONE
  } state_t;

  // Bits [7:4] are lanes spilling into the next word; non-zero means misaligned.
  function automatic logic [7:0] lane_mask(input logic [1:0] len, input logic [1:0] off);
    logic [7:0] base;
    case (len)
      LEN_BYTE: base = 8'h01;
      LEN_HALF: base = 8'h03;
      default:  base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: selects the addressed bytes out of one or two
// captured bus words and sign/zero-extends them to 32 bits.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_lo,
  input  logic [31:0] word_hi,
  input  logic [1:0]  offset,
  input  logic [1:0]  length,
  input  logic        sign,
  output logic [31:0] data
);

  logic [63:0] both;
  logic [31:0] win;

  assign both = {word_hi, word_lo};
  assign win  = both[{offset, 3'b000} +: 32];

  always_comb begin
    case (length)
      LEN_BYTE: data = {{24{sign & win[7]}}, win[7:0]};
      LEN_HALF: data = {{16{sign & win[15]}}, win[15:0]};
      default:  data = win;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer bridging the core to a req/ack memory bus.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two transfers.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  length,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        cap_lo, cap_sel, aligned, rdata_q;
  logic               err_q;
  logic [7:0]         mask;
  logic [63:0]        wide_wdata;
  logic               req, reserved, crosses, illegal, split, active, timeout;
  logic               go_req1, go_req2, fin, fin_err;

  assign req        = memread | memwrite;
  assign mask       = lane_mask(length, addr[1:0]);
  assign wide_wdata = {32'b0, wdata} << {addr[1:0], 3'b000};
  assign reserved   = (length == 2'b11);
  assign crosses    = |mask[7:4];

`ifdef LSU_MISALIGN_SPLIT_EN
  assign illegal = reserved;
  assign split   = crosses;
`else
  assign illegal = reserved | crosses;
  assign split   = 1'b0;
`endif

  assign active  = (state == ST_REQ1) || (state == ST_REQ2);
  assign timeout = active && !bus_ack && (cnt == CNT_W'(BUS_TIMEOUT - 1));
  assign bus_req = active;
  assign done    = (state == ST_DONE);
  assign err     = done & err_q;
  assign rdata   = rdata_q;
  // The low word of a split load was captured in REQ1; otherwise it is on the bus now.
  assign cap_sel = (state == ST_REQ2) ? cap_lo : bus_rdata;

  load_align u_align (
    .word_lo(cap_sel),
    .word_hi(bus_rdata),
    .offset (addr[1:0]),
    .length (length),
    .sign   (sign),
    .data   (aligned)
  );

  always_comb begin
    state_d = state;
    stall   = 1'b0;
    go_req1 = 1'b0;
    go_req2 = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by rst_n so a reset releases the core even if it still requests.
        stall = req & rst_n;
        if (req) begin
          if (illegal) begin
            state_d = ST_DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = ST_REQ1;
            go_req1 = 1'b1;
          end
        end
      end
      ST_REQ1, ST_REQ2: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (state == ST_REQ1 && split) begin
            state_d = ST_REQ2;
            go_req2 = 1'b1;
          end else begin
            state_d = ST_DONE;
            fin     = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      cap_lo    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_d;
      if (go_req1) begin
        cnt       <= '0;
        bus_we    <= memwrite;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= mask[3:0];
        bus_wdata <= wide_wdata[31:0];
      end else if (go_req2) begin
        cnt       <= '0;
        cap_lo    <= bus_rdata;
        bus_addr  <= {addr[31:2], 2'b00} + 32'd4;
        bus_be    <= mask[7:4];
        bus_wdata <= wide_wdata[63:32];
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fin) begin
        err_q   <= fin_err;
        rdata_q <= (fin_err || memwrite) ? 32'd0 : aligned;
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: table of accesses with a cycle-level bus responder,
// plus hand sequences for reset, late ack after timeout and reset mid-transfer.
module tb_lsu_sequencer;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite, sign;
  logic [1:0]  length;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_sequencer #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .length(length), .sign(sign), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] a, wd;
    int          waits;
    logic [31:0] w0, w1, e_rdata;
    logic        e_err;
    int          e_stall, e_nreq;
    logic [31:0] e_addr0;
    logic [3:0]  e_be0;
    logic [31:0] e_wdata0, e_addr1;
    logic [3:0]  e_be1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] len, input logic sgn,
                              input logic [31:0] a, wd, input int waits,
                              input logic [31:0] w0, w1, e_rdata, input logic e_err,
                              input int e_stall, e_nreq, input logic [31:0] e_addr0,
                              input logic [3:0] e_be0, input logic [31:0] e_wdata0,
                              input logic [31:0] e_addr1, input logic [3:0] e_be1);
    vec_t v;
    v.rd = rd; v.wr = wr; v.len = len; v.sgn = sgn; v.a = a; v.wd = wd; v.waits = waits;
    v.w0 = w0; v.w1 = w1; v.e_rdata = e_rdata; v.e_err = e_err; v.e_stall = e_stall;
    v.e_nreq = e_nreq; v.e_addr0 = e_addr0; v.e_be0 = e_be0; v.e_wdata0 = e_wdata0;
    v.e_addr1 = e_addr1; v.e_be1 = e_be1;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int stalls = 0, nreq = 0, waited = 0;
    logic in_txn = 1'b0, got_done = 1'b0, e = 1'b0, we0 = 1'b0;
    logic [31:0] r = '0, a0 = '0, a1 = '0, wd0 = '0;
    logic [3:0]  b0 = '0, b1 = '0;
    @(negedge clk);
    memread = v.rd; memwrite = v.wr; length = v.len; sign = v.sgn;
    addr = v.a; wdata = v.wd; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 30 && !got_done; cyc++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        got_done = 1'b1; r = rdata; e = err;
        memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b0;
      end else if (bus_req) begin
        if (!in_txn) begin
          nreq++; in_txn = 1'b1; waited = 0;
          if (nreq == 1) begin a0 = bus_addr; b0 = bus_be; wd0 = bus_wdata; we0 = bus_we; end
          else begin a1 = bus_addr; b1 = bus_be; end
        end
        if (waited >= v.waits) begin
          bus_ack = 1'b1; bus_rdata = (nreq == 1) ? v.w0 : v.w1; in_txn = 1'b0;
        end else begin
          bus_ack = 1'b0; waited++;
        end
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
    end
    if (!got_done) begin
      chk({tag, " done_seen"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " rdata"}, r, v.e_rdata);
      chk({tag, " err"}, {31'b0, e}, {31'b0, v.e_err});
      chk({tag, " stall_cycles"}, stalls, v.e_stall);
      chk({tag, " bus_transfers"}, nreq, v.e_nreq);
      if (v.e_nreq > 0) begin
        chk({tag, " bus_addr0"}, a0, v.e_addr0);
        chk({tag, " bus_be0"}, {28'b0, b0}, {28'b0, v.e_be0});
        chk({tag, " bus_we"}, {31'b0, we0}, {31'b0, v.wr});
        if (v.wr) chk({tag, " bus_wdata0"}, wd0, v.e_wdata0);
      end
      if (v.e_nreq > 1) begin
        chk({tag, " bus_addr1"}, a1, v.e_addr1);
        chk({tag, " bus_be1"}, {28'b0, b1}, {28'b0, v.e_be1});
      end
    end
  endtask

  vec_t vecs[12];
  string names[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bool_init: begin
      rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; length = LEN_WORD; sign = 1'b0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    end

    vecs[0]  = mk(1,0,LEN_WORD,0,32'h100,0,0,32'hDEADBEEF,0,32'hDEADBEEF,0,2,1,32'h100,4'hF,0,0,0);
    vecs[1]  = mk(1,0,LEN_BYTE,1,32'h103,0,0,32'h80FFFFFF,0,32'hFFFFFF80,0,2,1,32'h100,4'h8,0,0,0);
    vecs[2]  = mk(1,0,LEN_BYTE,0,32'h103,0,0,32'h80FFFFFF,0,32'h00000080,0,2,1,32'h100,4'h8,0,0,0);
    vecs[3]  = mk(0,1,LEN_HALF,0,32'h202,32'hABCD,3,0,0,0,0,5,1,32'h200,4'hC,32'hABCD0000,0,0);
    vecs[4]  = mk(1,0,LEN_HALF,1,32'h002,0,1,32'h80011234,0,32'hFFFF8001,0,3,1,32'h0,4'hC,0,0,0);
    vecs[5]  = mk(0,1,LEN_BYTE,0,32'h001,32'hA5,0,0,0,0,0,2,1,32'h0,4'h2,32'h0000A500,0,0);
    vecs[6]  = mk(1,0,2'b11,0,32'h010,0,0,32'h12345678,0,0,1,1,0,0,0,0,0,0);
    vecs[7]  = mk(1,0,LEN_WORD,0,32'h500,0,99,32'h12345678,0,0,1,5,1,32'h500,4'hF,0,0,0);
    vecs[8]  = mk(1,1,LEN_WORD,0,32'h040,32'hCAFEF00D,0,32'h11111111,0,0,0,2,1,32'h40,4'hF,32'hCAFEF00D,0,0);
    vecs[9]  = mk(1,0,LEN_HALF,0,32'h100,0,0,32'h1234ABCD,0,32'h0000ABCD,0,2,1,32'h100,4'h3,0,0,0);
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs[10] = mk(1,0,LEN_WORD,0,32'h301,0,0,32'h44332211,32'h88776655,32'h55443322,0,3,2,32'h300,4'hE,0,32'h304,4'h1);
    vecs[11] = mk(1,0,LEN_HALF,0,32'h403,0,0,32'h11223344,32'hAABBCCDD,32'h0000DD11,0,3,2,32'h400,4'h8,0,32'h404,4'h1);
`else
    vecs[10] = mk(1,0,LEN_WORD,0,32'h301,0,0,32'h44332211,32'h88776655,0,1,1,0,0,0,0,0,0);
    vecs[11] = mk(1,0,LEN_HALF,0,32'h403,0,0,32'h11223344,32'hAABBCCDD,0,1,1,0,0,0,0,0,0);
`endif
    names = '{"word_ld", "byte_ld_s", "byte_ld_u", "half_st", "half_ld_s", "byte_st",
              "reserved", "timeout", "rdwr_st", "half_ld_u", "mis_word", "mis_half"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst stall", {31'b0, stall}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run(vecs[i], names[i]);

    // Timeout followed by a late ack that must be ignored
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; length = LEN_WORD; addr = 32'h600; bus_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (done) break;
      @(negedge clk);
    end
    chk("late_ack done", {31'b0, done}, 32'd1);
    chk("late_ack err", {31'b0, err}, 32'd1);
    chk("late_ack rdata", rdata, 32'd0);
    memread = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    chk("late_ack bus_req", {31'b0, bus_req}, 32'd0);
    chk("late_ack no_done", {31'b0, done}, 32'd0);
    chk("late_ack stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("late_ack no_done2", {31'b0, done}, 32'd0);
    bus_ack = 1'b0;

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    memread = 1'b1; length = LEN_WORD; addr = 32'h700;
    @(negedge clk); #1;
    chk("midrst req_before", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst bus_req", {31'b0, bus_req}, 32'd0);
    chk("midrst stall", {31'b0, stall}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    memread = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst no_done", {31'b0, done}, 32'd0);
    run(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
